// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types and constants for the fetch/data memory port arbiter
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_D  = 2'd2
    } arb_state_t;
    localparam logic [3:0] FETCH_BE = 4'hF;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data, one transaction in flight,
// with bounded fetch starvation and redirect-killed fetch responses.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_kill,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        pc_write,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    arb_state_t    state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          kill_pend_q, kill_pend_d;
    logic          idle, d_win, if_win, if_resp;

    always_comb begin
        // grants are held off while reset is asserted so every output reads 0
        idle        = resetn && (state_q == IDLE);
        d_win       = idle && d_req && (!if_req || streak_q < STREAK_MAX);
        if_win      = idle && if_req && !d_win;
        if_resp     = (state_q == WAIT_IF) && mem_rvalid;
        if_gnt      = if_win;
        d_gnt       = d_win;
        mem_req     = d_win || if_win;
        mem_we      = d_win && d_we;
        mem_addr    = d_win ? d_addr : (if_win ? if_addr : '0);
        mem_wdata   = d_win ? d_wdata : '0;
        mem_be      = d_win ? d_be : (if_win ? FETCH_BE : '0);
        if_rvalid   = if_resp && !kill_pend_q && !if_kill;
        pc_write    = if_rvalid;
        if_rdata    = if_rvalid ? mem_rdata : '0;
        d_rvalid    = (state_q == WAIT_D) && mem_rvalid;
        d_rdata     = d_rvalid ? mem_rdata : '0;
        state_d     = d_win ? WAIT_D : if_win ? WAIT_IF :
                      (state_q != IDLE && mem_rvalid) ? IDLE : state_q;
        streak_d    = d_win ? (if_req ? ((streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1) : '0) :
                      (if_win ? '0 : streak_q);
        kill_pend_d = if_resp ? 1'b0 : (kill_pend_q || ((if_win || state_q == WAIT_IF) && if_kill));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            kill_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            kill_pend_q <= kill_pend_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios with a behavioural ownership model checked every cycle
// and literal expectations on the logged grant/response sequence.
module tb_mem_port_arbiter;
    localparam int MAXS = 4;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dreq_t;

    typedef struct {
        int          cyc;
        byte         kind;
        logic [31:0] data;
        logic [4:0]  aux;
    } ev_t;

    logic        clk = 0;
    logic        resetn = 0;
    logic        if_req = 0;
    logic [31:0] if_addr = 0;
    logic        if_kill = 0;
    logic        if_gnt, if_rvalid, pc_write;
    logic [31:0] if_rdata;
    logic        d_req = 0;
    logic        d_we = 0;
    logic [31:0] d_addr = 0;
    logic [31:0] d_wdata = 0;
    logic [3:0]  d_be = 0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_rvalid = 0;
    logic [31:0] mem_rdata = 0;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          mcnt = 0;
    logic [31:0] pend_addr = 0;
    bit          stray = 0;
    logic [31:0] fq[$];
    dreq_t       dq[$];
    ev_t         log_q[$];

    int m_owner = 0;
    int m_streak = 0;
    bit m_kill = 0;

    mem_port_arbiter #(.MAX_DATA_STREAK(MAXS)) dut (
        .clk(clk), .resetn(resetn),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .pc_write(pc_write),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_val(logic [31:0] a);
        return (a == 32'h100) ? 32'h0050_0093 : (a == 32'h2000) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0000);
    endfunction

    function automatic int cnt_ev(byte k);
        int n = 0;
        foreach (log_q[i]) if (log_q[i].kind == k) n++;
        return n;
    endfunction

    function automatic int ev_idx(byte k, int n);
        int seen = 0;
        foreach (log_q[i]) if (log_q[i].kind == k) begin
            if (seen == n) return i;
            seen++;
        end
        return -1;
    endfunction

    function automatic int ev_cyc(byte k, int n);
        int i = ev_idx(k, n);
        return (i < 0) ? -1000 : log_q[i].cyc;
    endfunction

    function automatic logic [31:0] ev_data(byte k, int n);
        int i = ev_idx(k, n);
        return (i < 0) ? 32'hFFFF_FFFF : log_q[i].data;
    endfunction

    // requesters hold each request until granted; memory answers lat cycles after a grant
    always @(posedge clk) begin
        logic fg, dg, mr;
        fg = if_gnt;
        dg = d_gnt;
        mr = mem_req;
        cyc++;
        if (mr) begin
            mcnt = lat;
            pend_addr = mem_addr;
        end
        #1;
        if (fg && fq.size() > 0) void'(fq.pop_front());
        if (dg && dq.size() > 0) void'(dq.pop_front());
        if_req  = fq.size() > 0;
        if_addr = (fq.size() > 0) ? fq[0] : 32'h0;
        d_req   = dq.size() > 0;
        d_we    = (dq.size() > 0) ? dq[0].we : 1'b0;
        d_addr  = (dq.size() > 0) ? dq[0].addr : 32'h0;
        d_wdata = (dq.size() > 0) ? dq[0].wdata : 32'h0;
        d_be    = (dq.size() > 0) ? dq[0].be : 4'h0;
        mem_rvalid = 0;
        mem_rdata  = 0;
        if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin
                mem_rvalid = 1;
                mem_rdata  = mem_val(pend_addr);
            end
        end
        if (stray) begin
            mem_rvalid = 1;
            mem_rdata  = 32'h1234_5678;
            stray = 0;
        end
    end

    // behavioural model: who owns the port, data streak length, whether the fetch in flight is dead
    always @(negedge clk) begin
        bit e_dg, e_ig, e_irv, e_drv;
        if (!resetn) begin
            m_owner = 0; m_streak = 0; m_kill = 0;
            e_dg = 0; e_ig = 0; e_irv = 0; e_drv = 0;
        end else begin
            e_dg  = (m_owner == 0) && d_req && (!if_req || m_streak < MAXS);
            e_ig  = (m_owner == 0) && if_req && !e_dg;
            e_irv = (m_owner == 1) && mem_rvalid && !m_kill && !if_kill;
            e_drv = (m_owner == 2) && mem_rvalid;
        end
        check("d_gnt", d_gnt, e_dg);
        check("if_gnt", if_gnt, e_ig);
        check("mem_req", mem_req, e_dg | e_ig);
        check("mem_we", mem_we, e_dg & d_we);
        check("mem_addr", mem_addr, e_dg ? d_addr : e_ig ? if_addr : 32'h0);
        check("mem_wdata", mem_wdata, e_dg ? d_wdata : 32'h0);
        check("mem_be", {28'h0, mem_be}, e_dg ? {28'h0, d_be} : e_ig ? 32'hF : 32'h0);
        check("if_rvalid", if_rvalid, e_irv);
        check("pc_write", pc_write, e_irv);
        check("d_rvalid", d_rvalid, e_drv);
        if (e_irv) check("if_rdata", if_rdata, mem_rdata);
        if (e_drv && !d_we) check("d_rdata", d_rdata, mem_rdata);
        if (!resetn) begin
            check("if_rdata_rst", if_rdata, 32'h0);
            check("d_rdata_rst", d_rdata, 32'h0);
        end
        if (d_gnt)     log_q.push_back('{cyc, "D", mem_addr, {mem_we, mem_be}});
        if (if_gnt)    log_q.push_back('{cyc, "I", mem_addr, {mem_we, mem_be}});
        if (if_rvalid) log_q.push_back('{cyc, "i", if_rdata, 5'h0});
        if (d_rvalid)  log_q.push_back('{cyc, "d", d_rdata, 5'h0});
        if (resetn) begin
            if (e_ig && if_kill) m_kill = 1;
            if (m_owner == 1 && if_kill) m_kill = 1;
            if (m_owner != 0 && mem_rvalid) begin
                if (m_owner == 1) m_kill = 0;
                m_owner = 0;
            end
            if (e_dg) begin
                m_owner = 2;
                m_streak = if_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
            end
            if (e_ig) begin
                m_owner = 1;
                m_streak = 0;
            end
        end
    end

    task automatic wait_ev(byte k, int n, string name);
        int c = 0;
        while (cnt_ev(k) < n && c < 300) begin
            @(negedge clk);
            #1;
            c++;
        end
        check(name, cnt_ev(k) >= n, 1);
    endtask

    task automatic settle(int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        string s;
        repeat (2) @(posedge clk);
        #2;
        check("rst_mem_req", mem_req, 0);
        check("rst_if_rvalid", if_rvalid, 0);
        @(posedge clk);
        #1 resetn = 1;
        settle(2);

        // fetch only, L=1
        log_q.delete();
        lat = 1;
        fq.push_back(32'h100);
        fq.push_back(32'h104);
        wait_ev("i", 2, "t1_wait");
        settle(2);
        check("t1_addr", ev_data("I", 0), 32'h100);
        check("t1_rv_lat", ev_cyc("i", 0) - ev_cyc("I", 0), 1);
        check("t1_rdata", ev_data("i", 0), 32'h0050_0093);
        check("t1_next_gnt", ev_cyc("I", 1) - ev_cyc("I", 0), 2);

        // simultaneous requests, L=2
        log_q.delete();
        lat = 2;
        dq.push_back('{1'b0, 32'h2000, 32'h0, 4'hF});
        fq.push_back(32'h300);
        wait_ev("i", 1, "t2_wait");
        settle(2);
        check("t2_d_first", ev_cyc("I", 0) > ev_cyc("D", 0), 1);
        check("t2_d_lat", ev_cyc("d", 0) - ev_cyc("D", 0), 2);
        check("t2_d_data", ev_data("d", 0), 32'hDEAD_BEEF);
        check("t2_if_gnt", ev_cyc("I", 0) - ev_cyc("d", 0), 1);

        // starvation bound: 6 data against 2 fetches
        log_q.delete();
        lat = 1;
        for (int i = 0; i < 6; i++) dq.push_back('{1'b1, 32'h3000 + 32'(i * 4), 32'(i), 4'hF});
        fq.push_back(32'h400);
        fq.push_back(32'h404);
        wait_ev("I", 2, "t3_wait_i");
        wait_ev("D", 6, "t3_wait_d");
        settle(3);
        s = "";
        foreach (log_q[i]) if (log_q[i].kind == "I" || log_q[i].kind == "D") s = $sformatf("%s%c", s, log_q[i].kind);
        checks++;
        if (s != "DDDDIDDI") begin
            errors++;
            $display("FAIL t3_order: got %s expected DDDDIDDI", s);
        end

        // kill in 2nd wait cycle, L=3
        log_q.delete();
        lat = 3;
        fq.push_back(32'h104);
        fq.push_back(32'h200);
        wait_ev("I", 1, "t4_wait_g");
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 if_kill = 1;
        @(posedge clk);
        #1 if_kill = 0;
        wait_ev("i", 1, "t4_wait_r");
        settle(3);
        check("t4_one_resp", cnt_ev("i"), 1);
        check("t4_addr2", ev_data("I", 1), 32'h200);
        check("t4_data", ev_data("i", 0), 32'hA5A5_0200);
        check("t4_lat", ev_cyc("i", 0) - ev_cyc("I", 1), 3);

        // store with partial byte enables
        log_q.delete();
        lat = 1;
        dq.push_back('{1'b1, 32'h2004, 32'hCAFE_F00D, 4'b0011});
        wait_ev("d", 1, "t5_wait");
        settle(2);
        check("t5_we_be", {27'h0, log_q[0].aux}, 32'h13);
        check("t5_ack", ev_cyc("d", 0) - ev_cyc("D", 0), 1);
        check("t5_no_if", cnt_ev("i"), 0);

        // reset during WAIT_D, then a stale and a stray response
        log_q.delete();
        lat = 4;
        dq.push_back('{1'b0, 32'h2008, 32'h0, 4'hF});
        wait_ev("D", 1, "t6_wait");
        @(posedge clk);
        #1 resetn = 0;
        #1;
        check("t6_mem_req", mem_req, 0);
        check("t6_d_rvalid", d_rvalid, 0);
        check("t6_mem_addr", mem_addr, 0);
        check("t6_mem_be", {28'h0, mem_be}, 0);
        @(posedge clk);
        #1 resetn = 1;
        settle(4);
        stray = 1;
        settle(3);
        check("t6_no_d", cnt_ev("d"), 0);
        check("t6_no_i", cnt_ev("i"), 0);
        lat = 1;
        fq.push_back(32'h100);
        wait_ev("i", 1, "t6_after");
        check("t6_after_data", ev_data("i", 0), 32'h0050_0093);
        settle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
